sevseg_scan_decoder: RTL and testbench

SEVSEG_SCAN_DECODER -- requirements
Module: sevseg_scan_decoder

---
 rtl/sevseg_scan_decoder.sv | 154 +++++++++++++++
 tb/tb_sevseg_scan_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sevseg_scan_decoder.sv
// Recovers the eight hex digits shown on a multiplexed, active-low seven-segment
// display by watching its anode/cathode lines and assembling complete frames.
module sevseg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  an,
  input  logic [0:6]  ca,
  output logic [31:0] value,
  output logic        value_valid,
  output logic [7:0]  digit_mask,
  output logic        digit_err,
  output logic        frame_err
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_PRE = 4'(STABLE_CYCLES - 1);

  // Sample stage and dwell tracking
  logic [7:0]  an_q, an_d;
  logic [6:0]  ca_q, ca_d;
  logic        seen_q, seen_d;
  logic [3:0]  cnt_q, cnt_d;

  // Frame assembly and outputs
  logic [31:0] slots_q, slots_d;
  logic [7:0]  mask_q, mask_d;
  logic [31:0] value_q, value_d;
  logic        valid_q, valid_d;
  logic        derr_q, derr_d;
  logic        ferr_q, ferr_d;

  logic        changed;
  logic        accept;
  logic        onehot_low;
  logic        blank;
  logic [2:0]  idx;
  logic        dec_ok;
  logic [3:0]  dec_nib;

  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    r = 5'b0_0000;
    case (pat)
      7'h01: r = {1'b1, 4'h0};
      7'h4F: r = {1'b1, 4'h1};
      7'h12: r = {1'b1, 4'h2};
      7'h06: r = {1'b1, 4'h3};
      7'h4C: r = {1'b1, 4'h4};
      7'h24: r = {1'b1, 4'h5};
      7'h20: r = {1'b1, 4'h6};
      7'h0F: r = {1'b1, 4'h7};
      7'h00: r = {1'b1, 4'h8};
      7'h04: r = {1'b1, 4'h9};
      7'h08: r = {1'b1, 4'hA};
      7'h60: r = {1'b1, 4'hB};
      7'h31: r = {1'b1, 4'hC};
      7'h42: r = {1'b1, 4'hD};
      7'h30: r = {1'b1, 4'hE};
      7'h38: r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // The word being sampled on this edge is compared with the one already held, so
  // the counter reflects the new sample; a dwell of N samples ends with cnt = N.
  always_comb begin
    an_d    = an;
    ca_d    = ca;
    seen_d  = 1'b1;
    changed = !seen_q || ({an, ca} != {an_q, ca_q});
    if (changed) begin
      cnt_d = 4'd1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
    accept = !changed && (cnt_q == CNT_PRE);
  end

  always_comb begin
    onehot_low = $onehot(~an_q);
    blank      = (an_q == 8'hFF);
    idx        = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an_q[i]) idx = 3'(i);
    end
    {dec_ok, dec_nib} = seg_decode(ca_q);
  end

  always_comb begin
    slots_d = slots_q;
    mask_d  = mask_q;
    value_d = value_q;
    valid_d = 1'b0;
    derr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (mask_q == 8'hFF) begin
      value_d = slots_q;
      valid_d = 1'b1;
      mask_d  = 8'h00;
    end
    // Blank anode words are the normal inter-digit gap and are silently skipped.
    if (accept && !blank) begin
      if (onehot_low) begin
        if (dec_ok) begin
          slots_d[{idx, 2'b00} +: 4] = dec_nib;
          mask_d[idx]                = 1'b1;
        end else begin
          derr_d = 1'b1;
        end
      end else begin
        ferr_d = 1'b1;
        mask_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q    <= 8'h00;
      ca_q    <= 7'h00;
      seen_q  <= 1'b0;
      cnt_q   <= 4'd0;
      slots_q <= 32'h0;
      mask_q  <= 8'h00;
      value_q <= 32'h0;
      valid_q <= 1'b0;
      derr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      an_q    <= an_d;
      ca_q    <= ca_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      slots_q <= slots_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      valid_q <= valid_d;
      derr_q  <= derr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign digit_mask  = mask_q;
  assign digit_err   = derr_q;
  assign frame_err   = ferr_q;

endmodule

// File: tb/tb_sevseg_scan_decoder.sv
// Directed-vector bench for sevseg_scan_decoder (STABLE_CYCLES = 4); inputs change
// on the falling edge, outputs and pulse counts are observed on the falling edge.
module tb_sevseg_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  an;
  logic [0:6]  ca;
  logic [31:0] value;
  logic        value_valid;
  logic [7:0]  digit_mask;
  logic        digit_err;
  logic        frame_err;

  int n_vec  = 0;
  int n_miss = 0;
  int vv_cnt = 0;
  int de_cnt = 0;
  int fe_cnt = 0;
  int vv0, de0, fe0;

  logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  sevseg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .ca          (ca),
    .value       (value),
    .value_valid (value_valid),
    .digit_mask  (digit_mask),
    .digit_err   (digit_err),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (value_valid) vv_cnt++;
    if (digit_err)   de_cnt++;
    if (frame_err)   fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents (a, c) for n sampling edges.
  task automatic hold(input logic [7:0] a, input logic [6:0] c, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      an = a;
      ca = c;
    end
  endtask

  task automatic digit(input int i, input logic [3:0] nib, input int n);
    logic [7:0] a;
    a = ~(8'h01 << i);
    hold(a, seg_tab[nib], n);
  endtask

  task automatic gap();
    hold(8'hFF, 7'h7F, 2);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n = 1'b0;
      an    = 8'hFF;
      ca    = 7'h7F;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic snap();
    vv0 = vv_cnt;
    de0 = de_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    rst_n = 1'b0;
    an    = 8'hFF;
    ca    = 7'h7F;
    do_reset(2);
    chk("rst_value", value, 32'h0);
    chk("rst_valid", {31'b0, value_valid}, 32'h0);
    chk("rst_mask",  {24'b0, digit_mask}, 32'h0);
    chk("rst_derr",  {31'b0, digit_err}, 32'h0);
    chk("rst_ferr",  {31'b0, frame_err}, 32'h0);

    // Full scan, digit 7 down to 0, each showing its own index
    snap();
    for (int i = 7; i >= 0; i--) digit(i, 4'(i), 6);
    gap();
    chk("scan_value", value, 32'h76543210);
    chk("scan_vv",    32'(vv_cnt - vv0), 32'd1);
    chk("scan_mask",  {24'b0, digit_mask}, 32'h0);
    chk("scan_errs",  32'(de_cnt - de0 + fe_cnt - fe0), 32'd0);

    // Dwell: three samples are not enough, the fourth accepts exactly
    hold(8'hFE, 7'h42, 3);
    gap();
    chk("dwell3_mask", {24'b0, digit_mask}, 32'h0);
    hold(8'hFE, 7'h42, 4);
    chk("dwell4_pre",  {24'b0, digit_mask}, 32'h0);
    @(negedge clk);
    chk("dwell4_post", {24'b0, digit_mask}, 32'h01);
    hold(8'hFE, 7'h42, 36);
    gap();
    chk("dwell40_mask", {24'b0, digit_mask}, 32'h01);

    // Undecodable pattern: one error per dwell, frame untouched
    snap();
    hold(8'hFB, 7'h7F, 6);
    gap();
    chk("derr_cnt",  32'(de_cnt - de0), 32'd1);
    chk("derr_mask", {24'b0, digit_mask}, 32'h01);
    hold(8'hFB, 7'h7F, 40);
    gap();
    chk("derr_long", 32'(de_cnt - de0), 32'd2);

    // Long blank: nothing happens
    snap();
    hold(8'hFF, 7'h7F, 20);
    chk("blank_pulses", 32'(vv_cnt - vv0 + de_cnt - de0 + fe_cnt - fe0), 32'd0);
    chk("blank_mask",   {24'b0, digit_mask}, 32'h01);
    chk("blank_value",  value, 32'h76543210);

    // Overwrite slot 0, capture 1..3, then an illegal anode word
    snap();
    digit(0, 4'h0, 6);
    for (int i = 1; i <= 3; i++) digit(i, 4'h5, 6);
    gap();
    chk("ovr_mask", {24'b0, digit_mask}, 32'h0F);
    chk("ovr_derr", 32'(de_cnt - de0), 32'd0);
    hold(8'hFC, 7'h01, 6);
    gap();
    chk("ferr_cnt",  32'(fe_cnt - fe0), 32'd1);
    chk("ferr_mask", {24'b0, digit_mask}, 32'h0);
    for (int i = 0; i < 8; i++) digit(i, 4'hA, 6);
    gap();
    chk("ferr_rescan", value, 32'hAAAAAAAA);
    chk("ferr_vv",     32'(vv_cnt - vv0), 32'd1);

    // Reset mid-frame discards the partial capture
    do_reset(0);
    do_reset(1);
    snap();
    for (int i = 0; i <= 6; i++) digit(i, 4'h3, 6);
    gap();
    chk("pre_rst_mask", {24'b0, digit_mask}, 32'h7F);
    do_reset(1);
    chk("mid_rst_value", value, 32'h0);
    digit(7, 4'h1, 6);
    gap();
    chk("post_rst_vv",    32'(vv_cnt - vv0), 32'd0);
    chk("post_rst_value", value, 32'h0);
    chk("post_rst_mask",  {24'b0, digit_mask}, 32'h80);

    // Back-to-back frames in opposite scan orders
    do_reset(1);
    snap();
    for (int i = 0; i < 8; i++) digit(i, 4'hF, 6);
    gap();
    chk("fwd_value", value, 32'hFFFFFFFF);
    for (int i = 7; i >= 0; i--) digit(i, 4'h8, 6);
    gap();
    chk("rev_value", value, 32'h88888888);
    chk("two_vv",    32'(vv_cnt - vv0), 32'd2);
    chk("two_mask",  {24'b0, digit_mask}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
